// File: rtl/shift_sched_rr.sv
`default_nettype none
// ============================================================================
// Module      : shift_sched_rr
// Description : Shares one bit-serial logical shifter between two requesters.
//               A round-robin arbiter grants the shifter, latches the winner's
//               operand/amount/direction, shifts one position per cycle and
//               returns the result with a one-cycle done pulse.
// Ports       : clk, reset_n (async, active low)
//               req0/dir0/data0/amt0, req1/dir1/data1/amt1 : requester inputs
//               gnt0/gnt1   : one-cycle grant pulses (operands latched)
//               done0/done1 : one-cycle completion pulses
//               result      : last completed result, held until next completion
//               busy        : high whenever the scheduler is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sched_rr #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic             dir0,
  input  logic [WIDTH-1:0] data0,
  input  logic [AMT_W-1:0] amt0,
  input  logic             req1,
  input  logic             dir1,
  input  logic [WIDTH-1:0] data1,
  input  logic [AMT_W-1:0] amt1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  // Counter must be able to hold WIDTH itself (saturated amount).
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q,  state_d;
  logic [WIDTH-1:0]   sreg_q,   sreg_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               dir_q,    dir_d;
  logic               owner_q,  owner_d;  // requester currently being served
  logic               last_q,   last_d;   // last-served pointer
  logic               gnt0_q,   gnt0_d;
  logic               gnt1_q,   gnt1_d;
  logic               done0_q,  done0_d;
  logic               done1_q,  done1_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q,   busy_d;

  logic               pick1;
  logic [AMT_W-1:0]   amt_sel;

  // Requester 1 wins when it is alone, or when both ask and 0 was served last.
  assign pick1   = req1 && (!req0 || !last_q);
  assign amt_sel = pick1 ? amt1 : amt0;

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    owner_d  = owner_q;
    last_d   = last_q;
    result_d = result_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          owner_d = pick1;
          sreg_d  = pick1 ? data1 : data0;
          dir_d   = pick1 ? dir1  : dir0;
          // Amounts of WIDTH or more all clear the operand; cap the cycle count.
          if (int'(amt_sel) >= WIDTH) begin
            cnt_d = CNT_W'(WIDTH);
          end else begin
            cnt_d = CNT_W'(amt_sel);
          end
          gnt0_d  = !pick1;
          gnt1_d  = pick1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (cnt_q != '0) begin
          sreg_d = dir_q ? (sreg_q >> 1) : (sreg_q << 1);
          cnt_d  = cnt_q - 1'b1;
        end else begin
          result_d = sreg_q;
          done0_d  = !owner_q;
          done1_d  = owner_q;
          last_d   = owner_q;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      sreg_q   <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      result_q <= result_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign result = result_q;
  assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_sched_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sched_rr
// Description : Self-checking bench for shift_sched_rr. Table-driven single
//               operations with a scoreboard queue, plus fairness and
//               reset-during-operation sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sched_rr;

  logic       clk;
  logic       reset_n;
  logic       req0, dir0, req1, dir1;
  logic [7:0] data0, amt0, data1, amt1;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [7:0] result;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit       sel;
    bit       dir;
    bit [7:0] data;
    bit [7:0] amt;
    bit [7:0] exp;
  } vec_t;

  typedef struct {
    bit       sel;
    bit [7:0] res;
    int       lat;
  } sb_t;

  sb_t sbq[$];
  int  ordq[$];
  vec_t tbl[9];

  shift_sched_rr #(.WIDTH(8), .AMT_W(8)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .req0   (req0),
    .dir0   (dir0),
    .data0  (data0),
    .amt0   (amt0),
    .req1   (req1),
    .dir1   (dir1),
    .data1  (data1),
    .amt1   (amt1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .done0  (done0),
    .done1  (done1),
    .result (result),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Continuous protocol checks: no overlapping or stretched pulses.
  logic prev_g0 = 0, prev_g1 = 0, prev_d0 = 0, prev_d1 = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      chk("gnt_overlap",  {31'd0, gnt0 & gnt1}, 32'd0);
      chk("done_overlap", {31'd0, done0 & done1}, 32'd0);
      chk("pulse_width",  {31'd0, (gnt0 & prev_g0) | (gnt1 & prev_g1) |
                                  (done0 & prev_d0) | (done1 & prev_d1)}, 32'd0);
    end
    prev_g0 = gnt0; prev_g1 = gnt1; prev_d0 = done0; prev_d1 = done1;
  end

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"},    {30'd0, gnt0, gnt1}, 32'd0);
    chk({tag, "_done"},   {30'd0, done0, done1}, 32'd0);
    chk({tag, "_result"}, {24'd0, result}, 32'd0);
    chk({tag, "_busy"},   {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_op(input vec_t v);
    int  n, k;
    bit  seen;
    sb_t e, got;
    n = (v.amt >= 8'd8) ? 8 : int'(v.amt);
    @(negedge clk);
    if (v.sel) begin
      req1 = 1'b1; dir1 = v.dir; data1 = v.data; amt1 = v.amt;
    end else begin
      req0 = 1'b1; dir0 = v.dir; data0 = v.data; amt0 = v.amt;
    end
    seen = 0;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (gnt0 || gnt1) seen = 1;
    end
    chk("gnt_seen", {31'd0, seen}, 32'd1);
    if (!seen) begin
      req0 = 1'b0; req1 = 1'b0;
      return;
    end
    chk("gnt_sel",  {30'd0, gnt1, gnt0}, {30'd0, v.sel, !v.sel});
    chk("gnt_busy", {31'd0, busy}, 32'd1);
    e.sel = v.sel; e.res = v.exp; e.lat = n + 1;
    sbq.push_back(e);
    // Drop the request and scramble operands: the operation must proceed.
    req0 = 1'b0; req1 = 1'b0;
    data0 = 8'($urandom); data1 = 8'($urandom);
    amt0 = 8'($urandom); amt1 = 8'($urandom);
    dir0 = ~dir0; dir1 = ~dir1;
    seen = 0;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (done0 || done1) seen = 1;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    got = sbq.pop_front();
    if (seen) begin
      chk("done_sel", {30'd0, done1, done0}, {30'd0, got.sel, !got.sel});
      chk("result",   {24'd0, result}, {24'd0, got.res});
      chk("latency",  k, got.lat);
      @(negedge clk);
      chk("idle_busy",   {31'd0, busy}, 32'd0);
      chk("result_hold", {24'd0, result}, {24'd0, got.res});
    end
  endtask

  initial begin
    int  ngr, low_run, cyc;
    bit  first;
    reset_n = 1'b0;
    req0 = 0; dir0 = 0; data0 = 0; amt0 = 0;
    req1 = 0; dir1 = 0; data1 = 0; amt1 = 0;

    tbl[0] = '{sel: 0, dir: 0, data: 8'h01, amt: 8'd0,   exp: 8'h01};
    tbl[1] = '{sel: 1, dir: 0, data: 8'hA5, amt: 8'd1,   exp: 8'h4A};
    tbl[2] = '{sel: 1, dir: 0, data: 8'hA5, amt: 8'd7,   exp: 8'h80};
    tbl[3] = '{sel: 0, dir: 1, data: 8'h80, amt: 8'd3,   exp: 8'h10};
    tbl[4] = '{sel: 0, dir: 0, data: 8'hFF, amt: 8'd200, exp: 8'h00};
    tbl[5] = '{sel: 1, dir: 1, data: 8'hC3, amt: 8'd2,   exp: 8'h30};
    tbl[6] = '{sel: 0, dir: 0, data: 8'h3C, amt: 8'd8,   exp: 8'h00};
    tbl[7] = '{sel: 1, dir: 1, data: 8'hFF, amt: 8'd7,   exp: 8'h01};
    tbl[8] = '{sel: 0, dir: 0, data: 8'h81, amt: 8'd4,   exp: 8'h10};

    do_reset();
    @(negedge clk);
    check_zero("post_reset");

    for (int i = 0; i < 9; i++) run_op(tbl[i]);

    // Fairness: both requests held continuously after reset.
    do_reset();
    req0 = 1; dir0 = 0; data0 = 8'h11; amt0 = 8'd2;
    req1 = 1; dir1 = 1; data1 = 8'h81; amt1 = 8'd1;
    ordq.push_back(0); ordq.push_back(1); ordq.push_back(0); ordq.push_back(1);
    ngr = 0; low_run = 0; first = 1; cyc = 0;
    while (ngr < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (gnt0 || gnt1) begin
        chk("rr_order", {31'd0, gnt1}, 32'(ordq.pop_front()));
        if (!first) chk("rr_gap", low_run, 1);
        first = 0;
        low_run = 0;
        ngr++;
      end else if (!busy) begin
        low_run++;
      end
    end
    chk("rr_grants", ngr, 4);
    req0 = 0; req1 = 0;
    repeat (10) @(negedge clk);
    chk("rr_last_result", {24'd0, result}, 32'h40);

    // Reset in the middle of a long operation.
    req0 = 1; dir0 = 0; data0 = 8'h0F; amt0 = 8'd6;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!gnt0 && cyc < 20);
    chk("abort_gnt0", {31'd0, gnt0}, 32'd1);
    req0 = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_zero("abort");
    ngr = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done0 || done1) ngr++;
    end
    chk("abort_no_done", ngr, 0);
    req0 = 1; req1 = 1;
    reset_n = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(gnt0 || gnt1) && cyc < 20);
    chk("after_abort_first", {30'd0, gnt1, gnt0}, 32'd1);
    req0 = 0; req1 = 0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/shift_sched_rr.md
Name: shift_sched_rr

Overview:
- Scheduler that shares one iterative, bit-serial shifter between two requesters.
- Round-robin arbiter grants the shifter to one requester and latches its operand, amount and direction.
- The shifter moves one bit position per cycle, then returns the result with a one-cycle done pulse.
- Used wherever variable logical shifts (<<, >>) are needed but a full barrel shifter per client is too large.

Parameters:
- WIDTH, 8, data/result width in bits.
- AMT_W, 8, shift-amount width in bits.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- req0  in  1  requester 0 request; held high until done0.
- dir0  in  1  requester 0 direction: 0 = left, 1 = logical right.
- data0  in  WIDTH  requester 0 operand.
- amt0  in  AMT_W  requester 0 shift amount, unsigned.
- req1, dir1, data1, amt1  in  1/1/WIDTH/AMT_W  requester 1, same meaning.
- gnt0  out  1  one-cycle pulse: requester 0 operands latched.
- gnt1  out  1  one-cycle pulse: requester 1 operands latched.
- done0  out  1  one-cycle pulse: result valid for requester 0.
- done1  out  1  one-cycle pulse: result valid for requester 1.
- result  out  WIDTH  last completed result; holds until the next completion.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; gnt0/1=0, done0/1=0, result=0, busy=0.
  - Shift register and counter cleared; last-served pointer=1, so requester 0 wins first.
  - Reset asserted mid-operation aborts it: no done pulse, result=0.
- All outputs are registered. States: IDLE, SHIFT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any req high at the edge: pick a winner, load sreg=data, dir, cnt=min(amt, WIDTH), pulse that requester's gnt, go to SHIFT.
- Arbitration:
  - Only one req high: it wins.
  - Both high: the requester not named by the last-served pointer wins.
  - The pointer updates to the winner on entry to DONE.
- SHIFT:
  - cnt!=0: sreg shifts one position (left: LSB gets 0; right: MSB gets 0), cnt decrements.
  - cnt==0: go to DONE; result<=sreg; pulse done for the owner.
- DONE: lasts one cycle, then returns to IDLE. No arbitration in DONE.
- Latency, with req sampled at edge E0:
  - gnt high after E0.
  - done and result valid after E0+n+1, where n=min(amt, WIDTH).
  - Amount 0 gives done after E0+1. The next grant is possible at E0+n+3.
- Width rules:
  - amt >= WIDTH saturates to WIDTH cycles; result=0.
  - The amount is unsigned; no arithmetic shift.
  - Bits shifted out are discarded.
- Request rules:
  - Deasserting req after gnt does not cancel the operation; done still pulses.
  - req, data, amt and dir are only sampled in IDLE; changes during SHIFT/DONE are ignored.
  - A req still high in IDLE after its own done is treated as a new request.
- gnt0/gnt1 are never high together, nor done0/done1. Pulses never exceed one cycle.

Test Plan:
- Left shift of 1 by 0: req0 with data0=8'h01, amt0=0, dir0=0 -> gnt0 after E0, done0 after E0+1, result=8'h01.
- 0xA5 left shifts: req1 with data1=8'hA5, dir1=0.
  - amt1=1 -> result=8'h4A.
  - amt1=7 -> result=8'h80; done1 exactly 8 cycles after gnt1.
- Right shift: data0=8'h80, dir0=1, amt0=3 -> result=8'h10.
- Saturation: amt0=8'd200, data0=8'hFF -> result=8'h00; done0 exactly 9 cycles after gnt0 (8 shift cycles + 1).
- Fairness: after reset, req0 and req1 held high continuously -> grant order 0,1,0,1; busy drops for exactly one cycle between operations; no overlapping pulses.
- Reset mid-operation: req0, amt0=6; pull reset_n low 3 cycles after gnt0 -> all outputs 0 immediately, no done0. After release with both reqs high -> gnt0 first.
